// File: rtl/mac_bank.sv
// mac_bank: a bank of NUM_MACS signed multiply-accumulate lanes computing
// VEC_LEN-beat dot products in parallel. Stage 1 registers the lane products,
// stage 2 accumulates them and loads the output register on the last beat.
// A held result (out_valid && !out_ready) freezes both stages.

module mac_bank #(
    parameter int NUM_MACS = 8,
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int ACC_W    = 24,
    parameter int VEC_LEN  = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_MACS*DATA_W-1:0]   datas,
    input  logic [NUM_MACS*WEIGHT_W-1:0] weights,
    input  logic [NUM_MACS-1:0]          lane_en,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         clear,
    output logic [NUM_MACS*ACC_W-1:0]    outs,
    output logic [NUM_MACS-1:0]          overflow,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int PROD_W = DATA_W + WEIGHT_W;
    localparam int CNT_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(VEC_LEN - 1);
    localparam logic [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};

    // Pipeline and output state
    logic [CNT_W-1:0]                   beat_cnt_q, beat_cnt_d;
    logic                               p_valid_q, p_valid_d;
    logic                               p_last_q, p_last_d;
    logic [NUM_MACS-1:0][PROD_W-1:0]    p_q, p_d;
    logic [NUM_MACS-1:0][ACC_W-1:0]     acc_q, acc_d;
    logic [NUM_MACS-1:0]                ovf_q, ovf_d;
    logic [NUM_MACS-1:0][ACC_W-1:0]     outs_q, outs_d;
    logic [NUM_MACS-1:0]                overflow_q, overflow_d;
    logic                               out_valid_q, out_valid_d;

    // Stage 2 lane arithmetic
    logic [NUM_MACS-1:0][ACC_W:0]       sum;
    logic [NUM_MACS-1:0]                range_err;
    logic [NUM_MACS-1:0][ACC_W-1:0]     lane_res;
    logic [NUM_MACS-1:0]                lane_ovf;

    logic stall;
    logic accept;

    // Signed product of one lane; operands are sign-extended to the full
    // product width so the multiply itself is exact.
    function automatic logic [PROD_W-1:0] mul_lane(input logic [DATA_W-1:0]   d,
                                                   input logic [WEIGHT_W-1:0] w);
        logic signed [PROD_W-1:0] de;
        logic signed [PROD_W-1:0] we;
        de = {{WEIGHT_W{d[DATA_W-1]}}, d};
        we = {{DATA_W{w[WEIGHT_W-1]}}, w};
        return de * we;
    endfunction

    assign stall     = out_valid_q && !out_ready;
    assign in_ready  = !stall && !clear && reset;
    assign accept    = in_valid && in_ready;
    assign outs      = outs_q;
    assign overflow  = overflow_q;
    assign out_valid = out_valid_q;

    // Per-lane accumulate with one guard bit; a guard/sign disagreement means
    // the sum left the accumulator range, which is clamped or wrapped.
    always_comb begin
        for (int i = 0; i < NUM_MACS; i++) begin
            sum[i] = {acc_q[i][ACC_W-1], acc_q[i]}
                   + {{(ACC_W+1-PROD_W){p_q[i][PROD_W-1]}}, p_q[i]};
            range_err[i] = sum[i][ACC_W] ^ sum[i][ACC_W-1];
            if (range_err[i] && SATURATE) begin
                lane_res[i] = sum[i][ACC_W] ? ACC_MIN : ACC_MAX;
            end else begin
                lane_res[i] = sum[i][ACC_W-1:0];
            end
        end
        lane_ovf = ovf_q | range_err;
    end

    // Next-state logic: output handshake, then clear, then the two pipeline
    // stages which advance together whenever no result is being held.
    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        p_valid_d   = p_valid_q;
        p_last_d    = p_last_q;
        p_d         = p_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        outs_d      = outs_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (clear) begin
            beat_cnt_d = '0;
            p_valid_d  = 1'b0;
            acc_d      = '0;
            ovf_d      = '0;
        end else if (!stall) begin
            p_valid_d = accept;
            if (accept) begin
                p_last_d = (beat_cnt_q == LAST_BEAT);
                for (int i = 0; i < NUM_MACS; i++) begin
                    p_d[i] = lane_en[i]
                           ? mul_lane(datas[i*DATA_W +: DATA_W], weights[i*WEIGHT_W +: WEIGHT_W])
                           : '0;
                end
                if (beat_cnt_q == LAST_BEAT) begin
                    beat_cnt_d = '0;
                end else begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end

            if (p_valid_q) begin
                if (p_last_q) begin
                    outs_d      = lane_res;
                    overflow_d  = lane_ovf;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    ovf_d       = '0;
                end else begin
                    acc_d = lane_res;
                    ovf_d = lane_ovf;
                end
            end
        end
    end

    // State registers, all cleared while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_cnt_q  <= '0;
            p_valid_q   <= 1'b0;
            p_last_q    <= 1'b0;
            p_q         <= '0;
            acc_q       <= '0;
            ovf_q       <= '0;
            outs_q      <= '0;
            overflow_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            p_valid_q   <= p_valid_d;
            p_last_q    <= p_last_d;
            p_q         <= p_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            outs_q      <= outs_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
